// File: rtl/uart_arb_pkg.sv
// Shared types and the round-robin search helper for the UART TX arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_GAP
  } arb_state_e;

  localparam int unsigned MAX_CH = 8;

  // First requesting index after 'last' (with wrap) among n channels; 'last' itself has lowest priority.
  function automatic int unsigned rr_next(input logic [MAX_CH-1:0] req,
                                          input int unsigned       last,
                                          input int unsigned       n);
    int unsigned pick;
    pick = last;
    for (int unsigned i = MAX_CH; i >= 1; i--) begin
      if (i <= n && req[(last + i) % n]) pick = (last + i) % n;
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Byte handshake between the arbiter and the shared uart_tx serializer.
interface uart_tx_arb_if;
  logic       uart_txreq;
  logic [7:0] uart_txdata;
  logic       uart_txend;

  modport master (output uart_txreq, output uart_txdata, input uart_txend);
  modport slave  (input uart_txreq, input uart_txdata, output uart_txend);
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: next requester after the last grant.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] last,
  output logic [$clog2(NUM_CH)-1:0] grant,
  output logic                      any
);
  localparam int unsigned IW = $clog2(NUM_CH);

  logic [MAX_CH-1:0] req_ext;

  always_comb begin
    req_ext             = '0;
    req_ext[NUM_CH-1:0] = req;
    grant               = IW'(rr_next(req_ext, 32'(last), NUM_CH));
    any                 = |req;
  end
endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one uart_tx among NUM_CH word FIFOs; words go out LSB byte first.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned WORD_BYTES  = 4,
  parameter int unsigned GAP_CYCLES  = 0,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           arb_en_i,
  input  logic [NUM_CH-1:0]              ch_empty_i,
  output logic [NUM_CH-1:0]              ch_rden_o,
  input  logic [NUM_CH*8*WORD_BYTES-1:0] ch_data_i,
  uart_tx_arb_if.master                  uart,
  output logic                           busy_o,
  output logic [$clog2(NUM_CH)-1:0]      cur_ch_o,
  output logic                           word_done_o,
  output logic                           err_timeout_o
);
  localparam int unsigned DW = 8 * WORD_BYTES;
  localparam int unsigned IW = $clog2(NUM_CH);
  localparam int unsigned BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  arb_state_e        state;
  logic [IW-1:0]     grant, last_grant, pick;
  logic              pick_any;
  logic [NUM_CH-1:0] req;
  logic [BW-1:0]     byte_idx, byte_nxt;
  logic [DW-1:0]     word_q;
  logic [GW-1:0]     gap_cnt;
  logic [TW-1:0]     to_cnt;
  logic              last_byte, step;

  assign req = ~ch_empty_i;

  uart_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req  (req),
    .last (last_grant),
    .grant(pick),
    .any  (pick_any)
  );

  // 'step' marks the end of a byte, either straight from WAIT or after the gap.
  always_comb begin
    last_byte = (byte_idx == BW'(WORD_BYTES - 1));
    byte_nxt  = byte_idx + 1'b1;
    step      = ((state == S_WAIT) && uart.uart_txend && (GAP_CYCLES == 0)) ||
                ((state == S_GAP) && (gap_cnt == GW'(GAP_CYCLES - 1)));
  end

  assign busy_o   = (state != S_IDLE);
  assign cur_ch_o = grant;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state            <= S_IDLE;
      grant            <= '0;
      last_grant       <= IW'(NUM_CH - 1);
      byte_idx         <= '0;
      word_q           <= '0;
      gap_cnt          <= '0;
      to_cnt           <= '0;
      ch_rden_o        <= '0;
      uart.uart_txreq  <= 1'b0;
      uart.uart_txdata <= '0;
      word_done_o      <= 1'b0;
      err_timeout_o    <= 1'b0;
    end else begin
      ch_rden_o       <= '0;
      uart.uart_txreq <= 1'b0;
      word_done_o     <= 1'b0;
      err_timeout_o   <= 1'b0;
      case (state)
        S_IDLE: if (arb_en_i && pick_any) begin
          grant     <= pick;
          byte_idx  <= '0;
          ch_rden_o <= NUM_CH'(1) << pick;
          state     <= S_RD;
        end
        S_RD: state <= S_LOAD;
        S_LOAD: begin
          word_q           <= ch_data_i[grant*DW +: DW];
          uart.uart_txreq  <= 1'b1;
          uart.uart_txdata <= ch_data_i[grant*DW +: 8];
          state            <= S_SEND;
        end
        S_SEND: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // txend wins over an expiry in the same cycle
          if (uart.uart_txend) begin
            if (GAP_CYCLES > 0) begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end else if (TIMEOUT_CYC > 0 && to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            err_timeout_o <= 1'b1;
            last_grant    <= grant;
            state         <= S_IDLE;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_GAP: if (!step) gap_cnt <= gap_cnt + 1'b1;
        default: state <= S_IDLE;
      endcase

      if (step) begin
        if (last_byte) begin
          word_done_o <= 1'b1;
          last_grant  <= grant;
          state       <= S_IDLE;
        end else begin
          byte_idx         <= byte_nxt;
          uart.uart_txreq  <= 1'b1;
          uart.uart_txdata <= word_q[8*byte_nxt +: 8];
          state            <= S_SEND;
        end
      end
    end
  end
endmodule
